// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a read-only fetch requester (I) and a read/write data requester
// (D) onto one shared single-port memory. Each granted access holds the memory
// port for LAT cycles, then the owner's done pulses for one cycle.
//
// Handshake: a requester raises *_req with its fields valid; the request is
// sampled only while the arbiter is IDLE. Address, write flag and write data
// are captured on the grant edge, so the requester may change them afterwards.
// The owner's *_done is high for exactly one cycle (RESP). Read data is valid
// on *_rdata from that cycle on and holds until that requester's next read
// completes. A req still high in the IDLE cycle after done is a new request.
//
// Parameters:
//   LAT          cycles the memory port is held per access (1..15)
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_req/i_addr/i_rdata/i_done                  fetch requester
//   d_req/d_wr/d_addr/d_wdata/d_rdata/d_done     data requester
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata   shared memory port
//   busy         high whenever the arbiter is not IDLE
//   o_dbg_state  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch requester
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    // data requester
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    // shared memory
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    // status
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      r_state;
    logic [1:0]  r_streak;     // consecutive D grants made while I was waiting
    logic [3:0]  r_cnt;        // remaining ACCESS cycles after the current one
    logic        r_owner_d;    // 1: D owns the access, 0: I owns it
    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        r_i_done;
    logic        r_d_done;

    // D wins unless it has already taken two grants in a row over a waiting I.
    logic w_grant_d;
    logic w_grant_i;

    assign w_grant_d = d_req && (!i_req || (r_streak < 2'd2));
    assign w_grant_i = !w_grant_d && i_req;

    // The memory-port registers double as the grant-time latch: they are only
    // needed while ACCESS lasts and must read zero everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_streak    <= 2'd0;
            r_cnt       <= 4'd0;
            r_owner_d   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_i_rdata   <= 16'h0000;
            r_d_rdata   <= 16'h0000;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse covering the RESP state only
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_ACCESS;
                        r_cnt       <= LAT_M1;
                        r_owner_d   <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= d_wr;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        if (i_req && (r_streak != 2'd2)) begin
                            r_streak <= r_streak + 2'd1;
                        end
                    end else if (w_grant_i) begin
                        r_state     <= ST_ACCESS;
                        r_cnt       <= LAT_M1;
                        r_owner_d   <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= 16'h0000;
                        r_streak    <= 2'd0;
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // last ACCESS cycle: capture read data, release the port
                        r_state     <= ST_RESP;
                        r_mem_en    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= 16'h0000;
                        r_mem_wdata <= 16'h0000;
                        if (!r_mem_wr) begin
                            if (r_owner_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        if (r_owner_d) begin
                            r_d_done <= 1'b1;
                        end else begin
                            r_i_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign i_done      = r_i_done;
    assign d_done      = r_d_done;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule
